// File: rtl/mux_hex_display.sv
// Multiplexed seven-segment scanner for DIGITS hex digits. It supports per-digit decimal
// points and blanking, leading-zero suppression and PWM brightness. Display values are
// double-buffered and change only at frame boundaries. All outputs are registered.
module mux_hex_display #(
   parameter int unsigned DIGITS         = 4,
   parameter int unsigned DIV_BITS       = 16,
   parameter int unsigned BRIGHT_BITS    = 3,
   parameter bit          SEL_ACTIVE_LOW = 1'b1,
   parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
   input  logic                   Clk,
   input  logic                   reset_n,
   input  logic [4*DIGITS-1:0]    value,
   input  logic                   load,
   input  logic [DIGITS-1:0]      dp,
   input  logic [DIGITS-1:0]      blank,
   input  logic                   lz_suppress,
   input  logic [BRIGHT_BITS-1:0] brightness,
   output logic [DIGITS-1:0]      SEG_SEL,
   output logic [6:0]             HEX_OUT,
   output logic                   DP_OUT,
   output logic                   frame_done
);

   localparam int unsigned      IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
   // XOR masks that turn active-high internal levels into pin polarity
   localparam logic [DIGITS-1:0] SEL_OFF = {DIGITS{SEL_ACTIVE_LOW}};
   localparam logic [6:0]        HEX_OFF = {7{SEG_ACTIVE_LOW}};
   localparam logic              DP_OFF  = SEG_ACTIVE_LOW;

   logic [DIV_BITS-1:0] r_pre;
   logic [IDX_W-1:0]    r_idx;
   logic [4*DIGITS-1:0] r_disp_val, r_pend_val;
   logic [DIGITS-1:0]   r_disp_dp, r_pend_dp;
   logic [DIGITS-1:0]   r_disp_blank, r_pend_blank;
   logic                r_pend_valid;

   logic                w_tc, w_boundary;
   logic [IDX_W-1:0]    w_dig;
   logic [3:0]          w_nib;
   logic                w_dp, w_blank, w_supp_cur, w_lead, w_pwm_on, w_lit;
   logic [DIGITS-1:0]   w_supp;
   logic [6:0]          w_glyph;
   logic [DIGITS-1:0]   w_sel_d;
   logic [6:0]          w_hex_d;
   logic                w_dp_d;

   assign w_tc       = &r_pre;
   assign w_boundary = w_tc && (r_idx == LAST_IDX);

   // Prescaler and scan index; index steps once per prescaler wrap
   always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pre <= '0;
         r_idx <= '0;
      end else begin
         r_pre <= r_pre + 1'b1;
         if (w_tc) r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
      end
   end

   // Double buffer: loads park in pending, display register only changes at frame boundary
   always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pend_val   <= '0;
         r_pend_dp    <= '0;
         r_pend_blank <= '0;
         r_pend_valid <= 1'b0;
         r_disp_val   <= '0;
         r_disp_dp    <= '0;
         r_disp_blank <= '0;
      end else begin
         if (load) begin
            r_pend_val   <= value;
            r_pend_dp    <= dp;
            r_pend_blank <= blank;
         end
         if (w_boundary) begin
            // A load in the boundary cycle bypasses pending and is consumed immediately
            if (load) begin
               r_disp_val   <= value;
               r_disp_dp    <= dp;
               r_disp_blank <= blank;
            end else if (r_pend_valid) begin
               r_disp_val   <= r_pend_val;
               r_disp_dp    <= r_pend_dp;
               r_disp_blank <= r_pend_blank;
            end
            r_pend_valid <= 1'b0;
         end else if (load) begin
            r_pend_valid <= 1'b1;
         end
      end
   end

   // Leading-zero mask, walking down from the most significant digit
   always_comb begin
      w_supp = '0;
      w_lead = 1'b1;
      for (int j = int'(DIGITS) - 1; j >= 0; j--) begin
         w_lead    = w_lead & (r_disp_val[j*4 +: 4] == 4'h0) & ~r_disp_dp[j];
         w_supp[j] = lz_suppress & w_lead & (j != 0);
      end
   end

   // Select the current digit's nibble and attributes; idx 0 shows the MSD
   always_comb begin
      w_dig      = LAST_IDX - r_idx;
      w_nib      = 4'h0;
      w_dp       = 1'b0;
      w_blank    = 1'b0;
      w_supp_cur = 1'b0;
      for (int k = 0; k < int'(DIGITS); k++) begin
         if (k == int'(w_dig)) begin
            w_nib      = r_disp_val[k*4 +: 4];
            w_dp       = r_disp_dp[k];
            w_blank    = r_disp_blank[k];
            w_supp_cur = w_supp[k];
         end
      end
   end

   // Hex glyph decode, active-high, bit 0 = segment a
   always_comb begin
      case (w_nib)
         4'h0:    w_glyph = 7'h3F;
         4'h1:    w_glyph = 7'h06;
         4'h2:    w_glyph = 7'h5B;
         4'h3:    w_glyph = 7'h4F;
         4'h4:    w_glyph = 7'h66;
         4'h5:    w_glyph = 7'h6D;
         4'h6:    w_glyph = 7'h7D;
         4'h7:    w_glyph = 7'h07;
         4'h8:    w_glyph = 7'h7F;
         4'h9:    w_glyph = 7'h6F;
         4'hA:    w_glyph = 7'h77;
         4'hB:    w_glyph = 7'h7C;
         4'hC:    w_glyph = 7'h39;
         4'hD:    w_glyph = 7'h5E;
         4'hE:    w_glyph = 7'h79;
         default: w_glyph = 7'h71;
      endcase
   end

   // Next output values; select stays asserted even when the digit is dark
   always_comb begin
      w_pwm_on = (r_pre[DIV_BITS-1 -: BRIGHT_BITS] <= brightness);
      w_lit    = ~w_blank & ~w_supp_cur & w_pwm_on;
      w_sel_d  = (DIGITS'(1) << r_idx) ^ SEL_OFF;
      w_hex_d  = (w_lit ? w_glyph : 7'h00) ^ HEX_OFF;
      w_dp_d   = (w_lit & w_dp) ^ DP_OFF;
   end

   // Output register stage
   always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) begin
         SEG_SEL    <= SEL_OFF;
         HEX_OUT    <= HEX_OFF;
         DP_OUT     <= DP_OFF;
         frame_done <= 1'b0;
      end else begin
         SEG_SEL    <= w_sel_d;
         HEX_OUT    <= w_hex_d;
         DP_OUT     <= w_dp_d;
         frame_done <= w_boundary;
      end
   end

endmodule

// File: tb/tb_mux_hex_display.sv
// Scoreboard bench for mux_hex_display (4 digits, 16-cycle slots, active-low pins).
module tb_mux_hex_display;

   localparam int DIGITS = 4;
   localparam int DIV_BITS = 4;
   localparam int BRIGHT_BITS = 2;
   localparam int SLOT = 16;
   localparam int FRAME = 64;

   logic                   Clk;
   logic                   reset_n;
   logic [4*DIGITS-1:0]    value;
   logic                   load;
   logic [DIGITS-1:0]      dp;
   logic [DIGITS-1:0]      blank;
   logic                   lz_suppress;
   logic [BRIGHT_BITS-1:0] brightness;
   logic [DIGITS-1:0]      SEG_SEL;
   logic [6:0]             HEX_OUT;
   logic                   DP_OUT;
   logic                   frame_done;

   mux_hex_display #(
      .DIGITS(DIGITS), .DIV_BITS(DIV_BITS), .BRIGHT_BITS(BRIGHT_BITS),
      .SEL_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
   ) dut (
      .Clk(Clk), .reset_n(reset_n), .value(value), .load(load), .dp(dp), .blank(blank),
      .lz_suppress(lz_suppress), .brightness(brightness), .SEG_SEL(SEG_SEL),
      .HEX_OUT(HEX_OUT), .DP_OUT(DP_OUT), .frame_done(frame_done)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct packed {
      logic [3:0] sel;
      logic [6:0] hex;
      logic       dp;
      logic       fd;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   logic [6:0] glyph [16];
   initial glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                     7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   // Reference model: frame-level state indexed by cycles since reset release
   int          m_cnt, m_pre, m_slot, m_dig;
   logic [15:0] m_val, p_val;
   logic [3:0]  m_dp, m_bl, p_dp, p_bl;
   bit          p_v, m_sup, m_lit;
   exp_t        m_e;

   initial forever begin
      @(posedge Clk);
      if (reset_n !== 1'b1) begin
         m_cnt = 0; m_val = '0; m_dp = '0; m_bl = '0;
         p_val = '0; p_dp = '0; p_bl = '0; p_v = 1'b0;
      end else begin
         m_pre  = m_cnt % SLOT;
         m_slot = (m_cnt / SLOT) % DIGITS;
         m_dig  = DIGITS - 1 - m_slot;
         m_sup  = lz_suppress && (m_dig != 0) && ((m_val >> (4 * m_dig)) == 16'd0)
                  && ((m_dp >> m_dig) == 4'd0);
         m_lit  = !m_bl[m_dig] && !m_sup && ((m_pre / 4) <= int'(brightness));
         m_e.sel = ~(4'b0001 << m_slot);
         m_e.hex = m_lit ? ~glyph[4'(m_val >> (4 * m_dig))] : 7'h7F;
         m_e.dp  = !(m_lit && m_dp[m_dig]);
         m_e.fd  = (m_cnt % FRAME) == FRAME - 1;
         exp_q.push_back(m_e);
         if ((m_cnt % FRAME) == FRAME - 1) begin
            if (load) begin
               m_val = value; m_dp = dp; m_bl = blank;
            end else if (p_v) begin
               m_val = p_val; m_dp = p_dp; m_bl = p_bl;
            end
            p_v = 1'b0;
         end else if (load) begin
            p_val = value; p_dp = dp; p_bl = blank; p_v = 1'b1;
         end
         m_cnt++;
      end
   end

   // An asserted reset overrides anything still queued
   initial forever begin
      @(negedge reset_n);
      exp_q.delete();
   end

   // Monitor: one comparison per cycle, sampled on the falling edge
   exp_t mon_e;
   initial forever begin
      @(negedge Clk);
      if (reset_n === 1'b0) begin
         n_cmp++;
         if (SEG_SEL !== 4'hF || HEX_OUT !== 7'h7F || DP_OUT !== 1'b1 || frame_done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs t=%0t got sel=%b hex=%b dp=%b fd=%b want sel=1111 hex=1111111 dp=1 fd=0",
                     $time, SEG_SEL, HEX_OUT, DP_OUT, frame_done);
         end
      end else if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         n_cmp++;
         if ({SEG_SEL, HEX_OUT, DP_OUT, frame_done} !== mon_e) begin
            n_bad++;
            $display("FAIL scan_output t=%0t got sel=%b hex=%b dp=%b fd=%b want sel=%b hex=%b dp=%b fd=%b",
                     $time, SEG_SEL, HEX_OUT, DP_OUT, frame_done,
                     mon_e.sel, mon_e.hex, mon_e.dp, mon_e.fd);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge Clk);
         #1;
      end
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
      value = v; dp = d; blank = b; load = 1'b1;
      tick(1);
      load = 1'b0;
   endtask

   // Returns the number of falling edges until frame_done is seen, 0 on timeout
   task automatic wait_fd(output int n);
      n = 0;
      for (int i = 1; i <= 300; i++) begin
         @(negedge Clk);
         if (frame_done === 1'b1) begin
            n = i;
            break;
         end
      end
      if (n == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL frame_done_timeout got none in 300 cycles want pulse");
      end
   endtask

   logic [3:0] t1_sel [4];
   logic [6:0] t1_hex [4];
   int         n;

   initial begin
      t1_sel = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      t1_hex = '{7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110};
      reset_n = 1'b0; value = '0; load = 1'b0; dp = '0; blank = '0;
      lz_suppress = 1'b0; brightness = 2'd3;
      tick(3);
      reset_n = 1'b1;
      tick(2);

      // Basic display of 12AF with frame period check
      do_load(16'h12AF, 4'b0000, 4'b0000);
      wait_fd(n);
      for (int s = 0; s < 4; s++) begin
         repeat ((s == 0) ? 9 : 16) @(negedge Clk);
         n_cmp++;
         if (SEG_SEL !== t1_sel[s] || HEX_OUT !== t1_hex[s]) begin
            n_bad++;
            $display("FAIL basic_slot%0d got sel=%b hex=%b want sel=%b hex=%b",
                     s, SEG_SEL, HEX_OUT, t1_sel[s], t1_hex[s]);
         end
      end
      wait_fd(n);
      wait_fd(n);
      n_cmp++;
      if (n != FRAME) begin
         n_bad++;
         $display("FAIL frame_period got %0d want %0d", n, FRAME);
      end

      // Tear-free update, then a load coincident with the boundary cycle
      tick(10);
      do_load(16'h1111, 4'b0000, 4'b0000);
      tick(20);
      do_load(16'h2222, 4'b0000, 4'b0000);
      wait_fd(n);
      wait_fd(n);
      tick(FRAME - 1);
      do_load(16'h3C5E, 4'b1001, 4'b0000);
      wait_fd(n);
      wait_fd(n);

      // Leading-zero suppression
      lz_suppress = 1'b1;
      do_load(16'h0000, 4'b0000, 4'b0000);
      wait_fd(n); wait_fd(n);
      do_load(16'h0050, 4'b0100, 4'b0000);
      wait_fd(n); wait_fd(n);
      do_load(16'h0007, 4'b0000, 4'b0000);
      wait_fd(n); wait_fd(n);

      // Brightness and blanking
      lz_suppress = 1'b0;
      brightness = 2'd1;
      do_load(16'h12AF, 4'b1111, 4'b0010);
      wait_fd(n); wait_fd(n);
      brightness = 2'd0;
      wait_fd(n);
      brightness = 2'd2;
      wait_fd(n);

      // Randomised loads, attributes and live control changes
      for (int i = 0; i < 40; i++) begin
         tick($urandom_range(1, 90));
         if ($urandom_range(0, 3) == 0) brightness = 2'($urandom);
         if ($urandom_range(0, 3) == 0) lz_suppress = 1'($urandom);
         if ($urandom_range(0, 2) == 0)
            do_load(16'($urandom_range(0, 255)), 4'($urandom), 4'($urandom & 3));
         else
            do_load(16'($urandom), 4'($urandom), 4'($urandom));
      end
      wait_fd(n); wait_fd(n);

      // Reset during digit 2's slot with a load still pending
      brightness = 2'd3;
      lz_suppress = 1'b0;
      wait_fd(n);
      tick(40);
      do_load(16'hBEEF, 4'b1111, 4'b0000);
      reset_n = 1'b0;
      tick(2);
      reset_n = 1'b1;
      tick(3 * FRAME);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
